// File: rtl/mpu_pkg.sv
// mpu_pkg: privilege levels, region permission layout and fixed default memory map
package mpu_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    // Field order matches the cfg_perm bus: {en, u, x, w, r}
    typedef struct packed {
        logic en;
        logic u;
        logic x;
        logic w;
        logic r;
    } perm_t;

    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT  = 32'h0FFF_FFFF;
    localparam logic [31:0] MMIO_BASE  = 32'h4000_0000;
    localparam logic [31:0] MMIO_LIMIT = 32'h4FFF_FFFF;
    localparam logic [31:0] RAM_BASE   = 32'h8000_0000;
    localparam logic [31:0] RAM_LIMIT  = 32'h8FFF_FFFF;

    function automatic logic in_win(input logic [31:0] a, input logic [31:0] b, input logic [31:0] l);
        return (a >= b) && (a <= l);
    endfunction

endpackage

// File: rtl/mpu_region_match.sv
// mpu_region_match: bounds compare and privilege-qualified permission decode for one region
//   addr, cur_priv        access under check
//   base, limit, perm     stored region state
//   hit                   region enabled and base <= addr <= limit
//   r, w, x               permissions granted to the current privilege
module mpu_region_match
    import mpu_pkg::*;
(
    input  logic [31:0] addr,
    input  priv_e       cur_priv,
    input  logic [31:0] base,
    input  logic [31:0] limit,
    input  perm_t       perm,
    output logic        hit,
    output logic        r,
    output logic        w,
    output logic        x
);
    logic priv_ok;
    // A base above limit makes both compares impossible at once, so it never hits
    assign hit     = perm.en && (addr >= base) && (addr <= limit);
    assign priv_ok = (cur_priv != PRIV_U) || perm.u;
    assign r       = priv_ok & perm.r;
    assign w       = priv_ok & perm.w;
    assign x       = priv_ok & perm.x;
endmodule

// File: rtl/mpu.sv
// mpu: combinational memory protection check over NREG programmable regions plus a fixed default map
//   clk, rst_n                    clock, synchronous active-high reset (asserted when 1)
//   addr, is_fetch/load/store     access under check, cur_priv its privilege
//   cfg_we/idx/base/limit/perm    region register write port
//   allow, fault_exec/load/store  check result
module mpu
    import mpu_pkg::*;
#(
    parameter int NREG = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        is_fetch,
    input  logic        is_load,
    input  logic        is_store,
    input  priv_e       cur_priv,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_idx,
    input  logic [31:0] cfg_base,
    input  logic [31:0] cfg_limit,
    input  logic [4:0]  cfg_perm,
    output logic        allow,
    output logic        fault_exec,
    output logic        fault_load,
    output logic        fault_store
);
    logic [31:0] base_q  [NREG];
    logic [31:0] base_d  [NREG];
    logic [31:0] limit_q [NREG];
    logic [31:0] limit_d [NREG];
    perm_t       perm_q  [NREG];
    perm_t       perm_d  [NREG];
    perm_t       cfg_perm_wx;
    logic [NREG-1:0] hit, reg_r, reg_w, reg_x;
    logic in_rom, in_mmio, in_ram, sup;
    logic sel_r, sel_w, sel_x;
    // W^X: a writable region can never also be executable
    assign cfg_perm_wx = {cfg_perm[4:3], cfg_perm[2] & ~cfg_perm[1], cfg_perm[1:0]};
    // Indices at or above NREG match no loop iteration and are dropped
    always_comb begin
        base_d  = base_q;
        limit_d = limit_q;
        perm_d  = perm_q;
        for (int i = 0; i < NREG; i++) begin
            if (cfg_we && cfg_idx == 3'(i)) begin
                base_d[i]  = {cfg_base[31:2], 2'b00};
                limit_d[i] = {cfg_limit[31:2], 2'b11};
                perm_d[i]  = cfg_perm_wx;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            base_q  <= '{default: '0};
            limit_q <= '{default: '0};
            perm_q  <= '{default: '0};
        end else begin
            base_q  <= base_d;
            limit_q <= limit_d;
            perm_q  <= perm_d;
        end
    end
    for (genvar g = 0; g < NREG; g++) begin : g_rgn
        mpu_region_match u_match (
            .addr     (addr),
            .cur_priv (cur_priv),
            .base     (base_q[g]),
            .limit    (limit_q[g]),
            .perm     (perm_q[g]),
            .hit      (hit[g]),
            .r        (reg_r[g]),
            .w        (reg_w[g]),
            .x        (reg_x[g])
        );
    end
    assign in_rom  = in_win(addr, ROM_BASE, ROM_LIMIT);
    assign in_mmio = in_win(addr, MMIO_BASE, MMIO_LIMIT);
    assign in_ram  = in_win(addr, RAM_BASE, RAM_LIMIT);
    assign sup     = cur_priv != PRIV_U;
    // Walk from the highest index down so the lowest matching region is applied last
    always_comb begin
        sel_r = in_rom | (in_mmio & sup) | in_ram;
        sel_w = (in_mmio & sup) | in_ram;
        sel_x = in_rom;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_r = reg_r[i];
                sel_w = reg_w[i];
                sel_x = reg_x[i];
            end
        end
    end
    // RAM is never executable, whatever a region grants
    assign fault_exec  = is_fetch & ~(sel_x & ~in_ram);
    assign fault_load  = is_load & ~sel_r;
    assign fault_store = is_store & ~sel_w;
    assign allow       = (is_fetch | is_load | is_store) & ~(fault_exec | fault_load | fault_store);
endmodule

// File: tb/tb_mpu.sv
// tb_mpu: scoreboard bench for mpu; results packed as {allow, fault_exec, fault_load, fault_store}
module tb_mpu;
    import mpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        is_fetch, is_load, is_store;
    priv_e       cur_priv;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [31:0] cfg_base, cfg_limit;
    logic [4:0]  cfg_perm;
    logic        allow, fault_exec, fault_load, fault_store;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        logic [3:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    mpu #(.NREG(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .is_fetch    (is_fetch),
        .is_load     (is_load),
        .is_store    (is_store),
        .cur_priv    (cur_priv),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_base    (cfg_base),
        .cfg_limit   (cfg_limit),
        .cfg_perm    (cfg_perm),
        .allow       (allow),
        .fault_exec  (fault_exec),
        .fault_load  (fault_load),
        .fault_store (fault_store)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drives an access, queues its expectation, then compares once outputs settle
    task automatic probe(input string tag, input logic [31:0] a, input logic [2:0] fls,
                         input priv_e p, input logic [3:0] exp);
        sb_t e;
        addr = a;
        {is_fetch, is_load, is_store} = fls;
        cur_priv = p;
        sb.push_back('{tag, exp});
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 4'bxxxx, exp);
        end else begin
            e = sb.pop_front();
            check(e.tag, {allow, fault_exec, fault_load, fault_store}, e.exp);
        end
    endtask

    task automatic acc(input string tag, input logic [31:0] a, input logic [2:0] fls,
                       input priv_e p, input logic [3:0] exp);
        @(negedge clk);
        probe(tag, a, fls, p, exp);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [31:0] b, input logic [31:0] l, input logic [4:0] pm);
        @(negedge clk);
        cfg_idx = idx; cfg_base = b; cfg_limit = l; cfg_perm = pm; cfg_we = 1'b1;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    localparam logic [2:0] F = 3'b100, L = 3'b010, S = 3'b001, NONE = 3'b000;

    initial begin
        rst_n = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_limit = '0; cfg_perm = '0;
        addr = '0; {is_fetch, is_load, is_store} = NONE; cur_priv = PRIV_M;
        // A region write attempted while reset is held must be discarded
        @(negedge clk);
        cfg_idx = 3'd0; cfg_base = 32'h1000_0000; cfg_limit = 32'h1000_00FF; cfg_perm = 5'b11011; cfg_we = 1'b1;
        probe("rst_nx_ram", 32'h8000_0000, F, PRIV_S, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; cfg_we = 1'b0;
        acc("nx_ram_s",       32'h8000_0000, F, PRIV_S, 4'b0100);
        acc("rom_fetch_u",    32'h0000_1000, F, PRIV_U, 4'b1000);
        acc("rom_store_u",    32'h0000_1000, S, PRIV_U, 4'b0001);
        acc("rom_load_u",     32'h0000_1000, L, PRIV_U, 4'b1000);
        acc("rst_we_ignored", 32'h1000_0010, L, PRIV_U, 4'b0010);
        acc("mmio_fetch_m",   32'h4000_0000, F, PRIV_M, 4'b0100);
        acc("ram_ld_st_m",    32'h8000_0004, L | S, PRIV_M, 4'b1000);
        acc("rom_top_fetch",  32'h0FFF_FFFF, F, PRIV_U, 4'b1000);
        acc("rom_past_fetch", 32'h1000_0000, F, PRIV_U, 4'b0100);
        acc("ram_top_store",  32'h8FFF_FFFF, S, PRIV_U, 4'b1000);
        // Same-cycle check must still see the old (empty) region state
        @(negedge clk);
        cfg_idx = 3'd0; cfg_base = 32'h8000_0000; cfg_limit = 32'h8000_0FFF; cfg_perm = 5'b10101; cfg_we = 1'b1;
        probe("same_cycle_old", 32'h8000_0010, S, PRIV_M, 4'b1000);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        acc("r0_fetch_hardnx", 32'h8000_0010, F, PRIV_M, 4'b0100);
        acc("r0_load",         32'h8000_0010, L, PRIV_M, 4'b1000);
        acc("r0_store_ovr",    32'h8000_0010, S, PRIV_M, 4'b0001);
        acc("r0_u_denied",     32'h8000_0010, L, PRIV_U, 4'b0010);
        acc("r0_limit_incl",   32'h8000_0FFF, L, PRIV_M, 4'b1000);
        acc("r0_past_limit",   32'h8000_1000, S, PRIV_M, 4'b1000);
        wr(3'd1, 32'h2000_0000, 32'h2000_00FC, 5'b11111);
        acc("r1_wx_fetch",     32'h2000_0004, F, PRIV_U, 4'b0100);
        acc("r1_store_u",      32'h2000_0004, S, PRIV_U, 4'b1000);
        acc("r1_limit_forced", 32'h2000_00FF, L, PRIV_U, 4'b1000);
        acc("r1_past_limit",   32'h2000_0100, L, PRIV_U, 4'b0010);
        acc("mmio_load_u",     32'h4000_0000, L, PRIV_U, 4'b0010);
        acc("mmio_load_s",     32'h4000_0000, L, PRIV_S, 4'b1000);
        acc("no_qualifier",    32'h4000_0000, NONE, PRIV_S, 4'b0000);
        acc("no_qual_unmap",   32'h2000_0100, NONE, PRIV_U, 4'b0000);
        wr(3'd2, 32'h3000_0000, 32'h3000_00FF, 5'b10001);
        wr(3'd3, 32'h3000_0000, 32'h3000_00FF, 5'b10011);
        acc("overlap_low_wins", 32'h3000_0010, S, PRIV_S, 4'b0001);
        acc("overlap_load",     32'h3000_0010, L, PRIV_S, 4'b1000);
        wr(3'd2, 32'h3000_0100, 32'h3000_0000, 5'b10001);
        acc("base_gt_limit",    32'h3000_0010, S, PRIV_S, 4'b1000);
        wr(3'd5, 32'h6000_0000, 32'h6000_00FF, 5'b11011);
        acc("idx_oob_ignored",  32'h6000_0010, L, PRIV_U, 4'b0010);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        acc("rst_clears_r1",    32'h2000_0004, L, PRIV_U, 4'b0010);
        acc("rst_clears_r3",    32'h3000_0010, S, PRIV_S, 4'b0001);
        acc("rst_clears_r0",    32'h8000_0010, S, PRIV_M, 4'b1000);
        if (sb.size() != 0) check("sb_drained", 4'(sb.size()), 4'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end
endmodule

// File: doc/mpu.md
MPU -- requirements
Module: mpu

Interface
REQ-001 Parameter NREG, default 4: number of programmable regions (1..8).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-high reset (asserted when 1), sampled on clk rising edge.
REQ-004 addr  in  32  byte address of the access under check.
REQ-005 is_fetch / is_load / is_store  in  1 each  access-type qualifiers; any combination is legal.
REQ-006 cur_priv  in  priv_e  current privilege (PRIV_U, PRIV_S, PRIV_M).
REQ-007 cfg_we  in  1  region-register write strobe.
REQ-008 cfg_idx  in  3  region index; values >= NREG are ignored.
REQ-009 cfg_base, cfg_limit  in  32 each  inclusive region bounds, 4-byte granular (bits [1:0] forced to 0 on base and to 3 on limit).
REQ-010 cfg_perm  in  5  {en, u, x, w, r}.
REQ-011 allow  out  1  access permitted.
REQ-012 fault_exec / fault_load / fault_store  out  1 each  per-type violation.

Function
REQ-013 All checks are purely combinational from addr, is_*, cur_priv and region state; zero-cycle latency, no registered outputs.
REQ-014 Fixed default map, applied when no enabled programmable region matches: ROM 0x0000_0000-0x0FFF_FFFF = R,X; MMIO 0x4000_0000-0x4FFF_FFFF = R,W, S/M only; RAM 0x8000_0000-0x8FFF_FFFF = R,W, never X; all other addresses = no permission.
REQ-015 Programmable region i matches when en=1 and base_i <= addr <= limit_i (unsigned); lowest matching index wins and fully overrides the default map.
REQ-016 Region with base > limit never matches.
REQ-017 U-mode access to a matched region with u=0 faults for every asserted type; S and M are not restricted by the u bit.
REQ-018 Fetch from any address inside the RAM window faults at every privilege, even if a programmable region grants X (hard NX-RAM rule).
REQ-019 fault_exec = is_fetch & ~X-permitted; fault_load = is_load & ~R-permitted; fault_store = is_store & ~W-permitted.
REQ-020 allow = (is_fetch | is_load | is_store) & no fault asserted; allow = 0 and all faults 0 when no qualifier is asserted.
REQ-021 W^X: a cfg write with both w=1 and x=1 stores x=0 (w kept).
REQ-022 cfg write takes effect on the next rising edge; a check in the same cycle as the write uses the old region state.
REQ-023 cfg_we while rst_n=1 is ignored (reset wins).

Reset
REQ-024 On rst_n=1 at a rising edge, all region registers clear (en=0, base=0, limit=0, perm=0).
REQ-025 During and after reset, checks still operate combinationally using the default map; outputs are never forced by reset.

Structure
REQ-026 priv_e (2-bit enum PRIV_U=0, PRIV_S=1, PRIV_M=3) and the default-map base/limit constants live in the shared CPU package.
REQ-027 One sub-module, mpu_region_match (bounds compare plus permission decode for one region), instantiated NREG times; priority select in mpu.

Verification
REQ-028 After reset, PRIV_S, is_fetch=1, addr=0x8000_0000 -> fault_exec=1, allow=0.
REQ-029 After reset, PRIV_U, is_fetch=1, addr=0x0000_1000 -> fault_exec=0, allow=1; is_store=1 same addr -> fault_store=1.
REQ-030 Program region 0 base=0x8000_0000 limit=0x8000_0FFF perm=en,x,r; fetch 0x8000_0010 -> fault_exec=1 (hard NX); load -> allow=1.
REQ-031 Write region 1 with perm=en,u,w,x,r at 0x2000_0000-0x2000_00FF; fetch 0x2000_0004 -> fault_exec=1 (x dropped); store -> allow=1.
REQ-032 PRIV_U load 0x4000_0000 -> fault_load=1; PRIV_S same -> allow=1; no qualifiers -> allow=0, all faults 0.
REQ-033 Overlapping regions 0 (r only) and 1 (r,w), same range: store -> fault_store=1 (region 0 wins).
